seg7_scan_driver: RTL and testbench

- Consumer end of the 20-bit `seg_data` bus that the game-mode blocks produce (four 5-bit glyph codes, digit 3 in [19:15] through digit 0 in [4:0]).
- Latches one frame of codes, decodes each code to a 7-segment glyph, and time-multiplexes the four digits onto a common-cathode-bus / per-digit-anode board display.
- Blanks between digits to prevent ghosting; sits between the mode mux and the board pins.

---
 rtl/seg7_pkg.sv | 53 +++++
 rtl/seg7_glyph_rom.sv | 39 +++
 rtl/seg7_scan_driver.sv | 140 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared glyph-code definitions for the 7-segment display path.
// The game-mode blocks and the scan driver import the same constants so
// that a code written on seg_data always means the same glyph everywhere.
package seg7_pkg;

    typedef logic [4:0] glyph_code_t;

    // Numeric digits
    localparam glyph_code_t G_0     = 5'h00;
    localparam glyph_code_t G_1     = 5'h01;
    localparam glyph_code_t G_2     = 5'h02;
    localparam glyph_code_t G_3     = 5'h03;
    localparam glyph_code_t G_4     = 5'h04;
    localparam glyph_code_t G_5     = 5'h05;
    localparam glyph_code_t G_6     = 5'h06;
    localparam glyph_code_t G_7     = 5'h07;
    localparam glyph_code_t G_8     = 5'h08;
    localparam glyph_code_t G_9     = 5'h09;

    // Letters and blank
    localparam glyph_code_t G_B     = 5'h0A;
    localparam glyph_code_t G_S     = 5'h0B;
    localparam glyph_code_t G_L     = 5'h0C;
    localparam glyph_code_t G_D     = 5'h0D;
    localparam glyph_code_t G_E     = 5'h0E;
    localparam glyph_code_t G_BLANK = 5'h0F;

    // Extended set; every code above G_DASH renders blank
    localparam glyph_code_t G_R     = 5'h10;
    localparam glyph_code_t G_G     = 5'h11;
    localparam glyph_code_t G_O     = 5'h12;
    localparam glyph_code_t G_DASH  = 5'h13;

    // Four blank codes packed onto the 20-bit bus
    localparam logic [19:0] SEG_DATA_BLANK = 20'h7BDEF;

    // One latched frame: four glyph codes plus the decimal-point requests
    typedef struct packed {
        logic [19:0] codes;
        logic [3:0]  dp;
    } frame_t;

    // Pack four codes onto the seg_data bus, digit 3 in the top bits
    function automatic logic [19:0] pack_codes(
        input glyph_code_t d3,
        input glyph_code_t d2,
        input glyph_code_t d1,
        input glyph_code_t d0
    );
        return {d3, d2, d1, d0};
    endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational glyph decoder: 5-bit glyph code to an active-high
// segment pattern ordered {g,f,e,d,c,b,a}. Polarity is handled downstream.
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] pattern
);

    // Look up the segment pattern for the requested code
    always_comb begin
        // NOTE: default assignment first so every path drives pattern and no latch is inferred.
        pattern = 7'h00;
        case (code)
            G_0:     pattern = 7'h3F;
            G_1:     pattern = 7'h06;
            G_2:     pattern = 7'h5B;
            G_3:     pattern = 7'h4F;
            G_4:     pattern = 7'h66;
            G_5:     pattern = 7'h6D;
            G_6:     pattern = 7'h7D;
            G_7:     pattern = 7'h07;
            G_8:     pattern = 7'h7F;
            G_9:     pattern = 7'h6F;
            G_B:     pattern = 7'h7C;
            G_S:     pattern = 7'h6D;
            G_L:     pattern = 7'h38;
            G_D:     pattern = 7'h5E;
            G_E:     pattern = 7'h79;
            G_BLANK: pattern = 7'h00;
            G_R:     pattern = 7'h50;
            G_G:     pattern = 7'h6F;
            G_O:     pattern = 7'h5C;
            G_DASH:  pattern = 7'h40;
            default: pattern = 7'h00;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver. Latches a frame of glyph codes
// at the start of each scan, then lights one digit per slot with a dark
// gap at the start of every slot to keep the previous digit from ghosting.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES   = 100000,
    parameter int BLANK_CYCLES   = 2000,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [19:0] seg_data,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIGIT_CYCLES - BLANK_CYCLES - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    // Pin levels for "off"; XOR-ing an active-high value with these applies polarity
    localparam logic [3:0] AN_OFF  = {4{AN_ACTIVE_LOW}};
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

    localparam frame_t FRAME_RESET = '{codes: SEG_DATA_BLANK, dp: 4'h0};

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [1:0]       digit_idx;
    logic [1:0]       idx_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    frame_t           shadow;

    logic             latch_now;
    logic [4:0]       cur_code;
    logic [6:0]       cur_pattern;
    logic [3:0]       an_hi;
    logic [6:0]       seg_hi;
    logic             dp_hi;

    // A new frame is taken at the very first cycle of digit 0's blank gap
    assign latch_now = (state == ST_BLANK) && (digit_idx == 2'd0) && (cnt == '0);

    assign cur_code = shadow.codes[5*digit_idx +: 5];

    seg7_glyph_rom u_glyph_rom (
        .code    (cur_code),
        .pattern (cur_pattern)
    );

    // Slot sequencing: BLANK for BLANK_CYCLES, DRIVE for the rest, then next digit
    always_comb begin
        state_nxt = state;
        idx_nxt   = digit_idx;
        cnt_nxt   = cnt + CNT_W'(1);
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = ST_DRIVE;
                    cnt_nxt   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt == DRIVE_LAST) begin
                    state_nxt = ST_BLANK;
                    idx_nxt   = digit_idx + 2'd1;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_BLANK;
                idx_nxt   = 2'd0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Active-high view of what the current slot should show
    always_comb begin
        an_hi  = 4'h0;
        seg_hi = 7'h00;
        dp_hi  = 1'b0;
        if (state == ST_DRIVE) begin
            an_hi  = 4'b0001 << digit_idx;
            seg_hi = cur_pattern;
            dp_hi  = shadow.dp[digit_idx];
        end
    end

    // Scan state and frame shadow; disable parks the scan but keeps the last frame
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state     <= ST_BLANK;
            digit_idx <= 2'd0;
            cnt       <= '0;
            // NOTE: shadow is reset so a display enabled before any frame shows blanks, not garbage.
            shadow    <= FRAME_RESET;
        end else if (!enable) begin
            state     <= ST_BLANK;
            digit_idx <= 2'd0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            digit_idx <= idx_nxt;
            cnt       <= cnt_nxt;
            if (latch_now) begin
                shadow <= '{codes: seg_data, dp: dp_mask};
            end
        end
    end

    // Registered pin drivers with polarity applied last
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_hi ^ AN_OFF;
            seg        <= seg_hi ^ SEG_OFF;
            dp         <= dp_hi ^ DP_OFF;
            frame_tick <= latch_now;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 8-cycle slots (2 blank + 6 drive),
// so one frame is 32 cycles. fpos tracks the bench's own idea of where the
// last edge fell in the frame (0 = latch edge).
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [19:0] seg_data;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int n_vec;
    int n_err;
    int fpos;
    bit running;

    logic [6:0] glyph_tbl [32];

    typedef struct {
        string       name;
        logic [19:0] data;
        logic [3:0]  mask;
        int          n;
        logic [3:0]  an_e;
        logic [6:0]  seg_e;
        logic        dp_e;
        logic        tick_e;
    } vec_t;

    vec_t vq[$];

    seg7_scan_driver #(
        .DIGIT_CYCLES   (8),
        .BLANK_CYCLES   (2),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .seg_data   (seg_data),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] outs();
        return {an, seg, dp, frame_tick};
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {an,seg,dp,tick}=%h expected %h (fpos=%0d)", name, got, exp, fpos);
        end
    endtask

    // One clock edge, sampled 1 time unit later, with running monitors
    task automatic step();
        @(posedge clk);
        #1;
        if (running) fpos = (fpos + 1) % 32;
        check("tick_mon", {12'h000, frame_tick}, {12'h000, running && (fpos == 0)});
        if (!running || (fpos % 8) < 2)
            check("dark_mon", {1'b0, an, seg, dp}, {1'b0, 4'hF, 7'h7F, 1'b1});
    endtask

    task automatic advance_to(input int p);
        int guard;
        guard = 0;
        while (fpos != p && guard < 64) begin
            step();
            guard++;
        end
    endtask

    task automatic add(input string nm, input logic [19:0] d, input logic [3:0] m, input int n,
                       input logic [3:0] a, input logic [6:0] s, input logic p, input logic t);
        vec_t v;
        v.name = nm; v.data = d; v.mask = m; v.n = n;
        v.an_e = a; v.seg_e = s; v.dp_e = p; v.tick_e = t;
        vq.push_back(v);
    endtask

    initial begin
        logic [19:0] d;
        logic [3:0]  m;

        n_vec   = 0;
        n_err   = 0;
        fpos    = -1;
        running = 1'b0;

        glyph_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                      7'h7F, 7'h6F, 7'h7C, 7'h6D, 7'h38, 7'h5E, 7'h79, 7'h00,
                      7'h50, 7'h6F, 7'h5C, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00,
                      7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

        // Vectors from reset release; fpos after the row noted in the name
        add("blank_latch_f0",  20'h7BDEF, 4'h0, 1,  4'hF, 7'h7F, 1'b1, 1'b1);
        add("blank_gap_f1",    20'h7BDEF, 4'h0, 1,  4'hF, 7'h7F, 1'b1, 1'b0);
        add("blank_d0_f2",     20'h7BDEF, 4'h0, 1,  4'hE, 7'h7F, 1'b1, 1'b0);
        add("blank_d0_f7",     20'h7BDEF, 4'h0, 5,  4'hE, 7'h7F, 1'b1, 1'b0);
        add("blank_gap_f8",    20'h7BDEF, 4'h0, 1,  4'hF, 7'h7F, 1'b1, 1'b0);
        add("num_latch_f0",    {5'h01, 5'h02, 5'h03, 5'h08}, 4'b0001, 24, 4'hF, 7'h7F, 1'b1, 1'b1);
        add("num_d0_f2",       {5'h01, 5'h02, 5'h03, 5'h08}, 4'b0001, 2,  4'hE, 7'h00, 1'b0, 1'b0);
        add("num_d1_f10",      {5'h01, 5'h02, 5'h03, 5'h08}, 4'b0001, 8,  4'hD, 7'h30, 1'b1, 1'b0);
        add("num_d2_f18",      {5'h01, 5'h02, 5'h03, 5'h08}, 4'b0001, 8,  4'hB, 7'h24, 1'b1, 1'b0);
        add("num_d3_f26",      {5'h01, 5'h02, 5'h03, 5'h08}, 4'b0001, 8,  4'h7, 7'h79, 1'b1, 1'b0);
        add("num_d3_f31",      {5'h01, 5'h02, 5'h03, 5'h08}, 4'b0001, 5,  4'h7, 7'h79, 1'b1, 1'b0);
        add("num_period_f0",   {5'h01, 5'h02, 5'h03, 5'h08}, 4'b0001, 1,  4'hF, 7'h7F, 1'b1, 1'b1);
        add("err_latch_f0",    {5'h0F, 5'h0E, 5'h10, 5'h10}, 4'h0, 32, 4'hF, 7'h7F, 1'b1, 1'b1);
        add("err_d0_f2",       {5'h0F, 5'h0E, 5'h10, 5'h10}, 4'h0, 2,  4'hE, 7'h2F, 1'b1, 1'b0);
        add("err_d1_f10",      {5'h0F, 5'h0E, 5'h10, 5'h10}, 4'h0, 8,  4'hD, 7'h2F, 1'b1, 1'b0);
        add("err_d2_f18",      {5'h0F, 5'h0E, 5'h10, 5'h10}, 4'h0, 8,  4'hB, 7'h06, 1'b1, 1'b0);
        add("err_d3_f26",      {5'h0F, 5'h0E, 5'h10, 5'h10}, 4'h0, 8,  4'h7, 7'h7F, 1'b1, 1'b0);

        // Reset held for a few cycles
        reset    = 1'b1;
        enable   = 1'b1;
        seg_data = 20'h7BDEF;
        dp_mask  = 4'h0;
        repeat (3) step();
        check("in_reset", outs(), {4'hF, 7'h7F, 1'b1, 1'b0});

        reset   = 1'b0;
        running = 1'b1;
        fpos    = -1;

        foreach (vq[i]) begin
            seg_data = vq[i].data;
            dp_mask  = vq[i].mask;
            repeat (vq[i].n) step();
            check(vq[i].name, outs(), {vq[i].an_e, vq[i].seg_e, vq[i].dp_e, vq[i].tick_e});
        end

        // Mid-frame change is held off until the next latch
        advance_to(10);
        check("midchg_old_d1", outs(), {4'hD, 7'h2F, 1'b1, 1'b0});
        seg_data = {5'h08, 5'h00, 5'h05, 5'h09};
        dp_mask  = 4'b1010;
        step();
        check("midchg_hold_d1", outs(), {4'hD, 7'h2F, 1'b1, 1'b0});
        advance_to(26);
        check("midchg_hold_d3", outs(), {4'h7, 7'h7F, 1'b1, 1'b0});
        advance_to(0);
        check("midchg_latch", outs(), {4'hF, 7'h7F, 1'b1, 1'b1});
        advance_to(2);
        check("midchg_new_d0", outs(), {4'hE, 7'h10, 1'b1, 1'b0});
        advance_to(10);
        check("midchg_new_d1", outs(), {4'hD, 7'h12, 1'b0, 1'b0});

        // Reset during digit 2 drive aborts the scan
        advance_to(18);
        check("pre_reset_d2", outs(), {4'hB, 7'h40, 1'b1, 1'b0});
        reset   = 1'b1;
        running = 1'b0;
        step();
        check("reset_abort", outs(), {4'hF, 7'h7F, 1'b1, 1'b0});
        step();
        seg_data = {5'h13, 5'h12, 5'h11, 5'h0C};
        reset    = 1'b0;
        running  = 1'b1;
        fpos     = -1;
        step();
        check("reset_relatch", outs(), {4'hF, 7'h7F, 1'b1, 1'b1});
        advance_to(2);
        check("reset_restart_d0", outs(), {4'hE, 7'h47, 1'b1, 1'b0});

        // Enable dropped for 5 cycles during digit 1
        advance_to(10);
        check("pre_dis_d1", outs(), {4'hD, 7'h10, 1'b0, 1'b0});
        enable   = 1'b0;
        running  = 1'b0;
        seg_data = {5'h0A, 5'h0B, 5'h0D, 5'h01};
        step();
        check("dis_dark", outs(), {4'hF, 7'h7F, 1'b1, 1'b0});
        repeat (4) step();
        enable  = 1'b1;
        running = 1'b1;
        fpos    = -1;
        step();
        check("en_relatch", outs(), {4'hF, 7'h7F, 1'b1, 1'b1});
        advance_to(2);
        check("en_d0", outs(), {4'hE, 7'h79, 1'b1, 1'b0});
        advance_to(10);
        check("en_d1", outs(), {4'hD, 7'h21, 1'b0, 1'b0});
        advance_to(18);
        check("en_d2", outs(), {4'hB, 7'h12, 1'b1, 1'b0});
        advance_to(26);
        check("en_d3", outs(), {4'h7, 7'h03, 1'b0, 1'b0});

        // Sweep all 32 codes, four per frame, including the blank range
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < 4; i++) d[5*i +: 5] = 5'(4*g + i);
            m        = 4'(g + 5);
            seg_data = d;
            dp_mask  = m;
            step();
            advance_to(0);
            for (int i = 0; i < 4; i++) begin
                advance_to(8*i + 2);
                check($sformatf("sweep_code%0d_first", 4*g + i), outs(),
                      {~(4'b0001 << i), ~glyph_tbl[4*g + i], ~m[i], 1'b0});
                advance_to(8*i + 7);
                check($sformatf("sweep_code%0d_last", 4*g + i), outs(),
                      {~(4'b0001 << i), ~glyph_tbl[4*g + i], ~m[i], 1'b0});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
